// File: rtl/pma_multi.sv
// Physical-memory-address unit: base registers, fixed-priority source arbiter,
// latched PA for the memory port, freezable error address register and page sweep.
module pma_multi #(
  parameter int unsigned PA_W  = 22,
  parameter int unsigned PG_W  = 13,
  parameter int unsigned NBASE = 2,
  parameter int unsigned NCHAN = 2
) (
  input  logic                     clock,
  input  logic                     RESET_N,
  input  logic [PA_W-1:0]          VA,
  input  logic                     BASE_LOAD,
  input  logic [$clog2(NBASE)-1:0] BASE_IDX,
  input  logic [$clog2(NBASE)-1:0] BASE_SEL,
  input  logic                     EBOX_REQ,
  input  logic                     PT_REQ,
  input  logic [NCHAN-1:0]         CHAN_REQ,
  input  logic [NCHAN*PA_W-1:0]    CHA_ADDR,
  input  logic                     ERA_REQ,
  input  logic                     SWEEP_LOAD,
  input  logic                     SWEEP_STEP4,
  input  logic                     ACCEPT,
  input  logic                     ERR_IN,
  input  logic                     ERA_CLR,
  output logic [PA_W-1:0]          PA,
  output logic                     PA_PAR,
  output logic                     PA_VALID,
  output logic [NCHAN+3:0]         GRANT,
  output logic [PA_W-1:0]          ERA,
  output logic                     ERA_FROZEN,
  output logic                     ERR_OVF,
  output logic                     SWEEP_ACTIVE,
  output logic                     SWEEP_DONE
);

  localparam int unsigned OFS_W  = PA_W - PG_W;
  localparam int unsigned NG     = NCHAN + 4;
  localparam int unsigned G_ERA  = 0;
  localparam int unsigned G_SWP  = 1;
  localparam int unsigned G_PT   = NCHAN + 2;
  localparam int unsigned G_EBOX = NCHAN + 3;

  typedef enum logic {S_IDLE, S_CYCLE} state_t;

  state_t            state_q, state_d;
  logic              grant_en_c, accept_en_c;
  logic              any_req;
  logic              chan_hit;
  logic [PA_W-1:0]   chan_pa;
  logic [NG-1:0]     chan_grant;
  logic [PA_W-1:0]   win_pa;
  logic [NG-1:0]     win_grant;
  logic [PG_W-1:0]   base_q [NBASE];
  logic [PG_W-1:0]   pt_base;
  logic [PG_W-1:0]   sweep_page;
  logic [OFS_W-1:0]  sweep_cnt;
  logic              stride4;
  logic              sweep_acc;
  logic              sweep_end;

  // FSM state register
  always_ff @(posedge clock) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_CYCLE;
      S_CYCLE: if (ACCEPT)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM strobes: latch a winner in IDLE, retire the cycle on ACCEPT in CYCLE
  always_comb begin
    grant_en_c  = 1'b0;
    accept_en_c = 1'b0;
    case (state_q)
      S_IDLE:  grant_en_c  = any_req;
      S_CYCLE: accept_en_c = ACCEPT;
      default: ;
    endcase
  end

  assign any_req = ERA_REQ | SWEEP_ACTIVE | (|CHAN_REQ) | PT_REQ | EBOX_REQ;
  assign pt_base = (32'(BASE_SEL) < NBASE) ? base_q[BASE_SEL] : '0;

  // Lowest-index active channel
  always_comb begin
    chan_hit   = 1'b0;
    chan_pa    = '0;
    chan_grant = '0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      if (CHAN_REQ[i] && !chan_hit) begin
        chan_hit   = 1'b1;
        chan_pa    = CHA_ADDR[i*PA_W +: PA_W];
        chan_grant = NG'(1) << (i + 2);
      end
    end
  end

  // Fixed-priority source select
  always_comb begin
    win_pa    = '0;
    win_grant = '0;
    if (ERA_REQ) begin
      win_pa    = ERA;
      win_grant = NG'(1) << G_ERA;
    end else if (SWEEP_ACTIVE) begin
      win_pa    = {sweep_page, sweep_cnt};
      win_grant = NG'(1) << G_SWP;
    end else if (chan_hit) begin
      win_pa    = chan_pa;
      win_grant = chan_grant;
    end else if (PT_REQ) begin
      win_pa    = {pt_base, VA[OFS_W-1:0]};
      win_grant = NG'(1) << G_PT;
    end else if (EBOX_REQ) begin
      win_pa    = VA;
      win_grant = NG'(1) << G_EBOX;
    end
  end

  // Memory-port address latch
  always_ff @(posedge clock) begin
    if (!RESET_N) begin
      PA       <= '0;
      PA_PAR   <= 1'b1;
      PA_VALID <= 1'b0;
      GRANT    <= '0;
    end else if (grant_en_c) begin
      PA       <= win_pa;
      PA_PAR   <= ~^win_pa;
      PA_VALID <= 1'b1;
      GRANT    <= win_grant;
    end else if (accept_en_c) begin
      PA_VALID <= 1'b0;
      GRANT    <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(NBASE); i++) base_q[i] <= '0;
    end else if (BASE_LOAD && (32'(BASE_IDX) < NBASE)) begin
      base_q[BASE_IDX] <= VA[PA_W-1:OFS_W];
    end
  end

  // ERA capture happens before the freeze so the erroring address is kept
  always_ff @(posedge clock) begin
    if (!RESET_N) begin
      ERA        <= '0;
      ERA_FROZEN <= 1'b0;
      ERR_OVF    <= 1'b0;
    end else begin
      if (accept_en_c && !ERA_FROZEN) ERA <= PA;
      if (ERA_CLR) begin
        ERA_FROZEN <= ERR_IN;
        ERR_OVF    <= 1'b0;
      end else if (ERR_IN) begin
        if (ERA_FROZEN) ERR_OVF    <= 1'b1;
        else            ERA_FROZEN <= 1'b1;
      end
    end
  end

  // A new SWEEP_LOAD overrides the step/done of a sweep cycle retiring now
  assign sweep_acc = accept_en_c && GRANT[G_SWP] && !SWEEP_LOAD;
  assign sweep_end = stride4 ? (sweep_cnt[OFS_W-1:2] == '0) : (sweep_cnt == '0);

  always_ff @(posedge clock) begin
    if (!RESET_N) begin
      SWEEP_ACTIVE <= 1'b0;
      SWEEP_DONE   <= 1'b0;
      sweep_page   <= '0;
      sweep_cnt    <= '0;
      stride4      <= 1'b0;
    end else begin
      SWEEP_DONE <= 1'b0;
      if (SWEEP_LOAD) begin
        sweep_page   <= VA[PA_W-1:OFS_W];
        sweep_cnt    <= '1;
        stride4      <= SWEEP_STEP4;
        SWEEP_ACTIVE <= 1'b1;
      end else if (sweep_acc) begin
        if (sweep_end) begin
          SWEEP_ACTIVE <= 1'b0;
          SWEEP_DONE   <= 1'b1;
        end else begin
          sweep_cnt <= sweep_cnt - (stride4 ? OFS_W'(4) : OFS_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pma_multi.sv
// Scoreboard bench for pma_multi: expected PA/GRANT queued at stimulus time,
// popped and compared when the unit presents a cycle.
module tb_pma_multi;

  localparam int unsigned PA_W  = 22;
  localparam int unsigned PG_W  = 13;
  localparam int unsigned NBASE = 2;
  localparam int unsigned NCHAN = 2;
  localparam int unsigned NG    = NCHAN + 4;

  localparam logic [NG-1:0] G_ERA  = 6'h01;
  localparam logic [NG-1:0] G_SWP  = 6'h02;
  localparam logic [NG-1:0] G_CH0  = 6'h04;
  localparam logic [NG-1:0] G_CH1  = 6'h08;
  localparam logic [NG-1:0] G_PT   = 6'h10;
  localparam logic [NG-1:0] G_EBOX = 6'h20;

  logic                  clock;
  logic                  RESET_N;
  logic [PA_W-1:0]       VA;
  logic                  BASE_LOAD;
  logic [0:0]            BASE_IDX, BASE_SEL;
  logic                  EBOX_REQ, PT_REQ;
  logic [NCHAN-1:0]      CHAN_REQ;
  logic [NCHAN*PA_W-1:0] CHA_ADDR;
  logic                  ERA_REQ, SWEEP_LOAD, SWEEP_STEP4, ACCEPT, ERR_IN, ERA_CLR;
  logic [PA_W-1:0]       PA;
  logic                  PA_PAR, PA_VALID;
  logic [NG-1:0]         GRANT;
  logic [PA_W-1:0]       ERA;
  logic                  ERA_FROZEN, ERR_OVF, SWEEP_ACTIVE, SWEEP_DONE;

  typedef struct packed {
    logic [PA_W-1:0] pa;
    logic [NG-1:0]   grant;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pma_multi #(.PA_W(PA_W), .PG_W(PG_W), .NBASE(NBASE), .NCHAN(NCHAN)) dut (
    .clock(clock), .RESET_N(RESET_N), .VA(VA), .BASE_LOAD(BASE_LOAD),
    .BASE_IDX(BASE_IDX), .BASE_SEL(BASE_SEL), .EBOX_REQ(EBOX_REQ), .PT_REQ(PT_REQ),
    .CHAN_REQ(CHAN_REQ), .CHA_ADDR(CHA_ADDR), .ERA_REQ(ERA_REQ),
    .SWEEP_LOAD(SWEEP_LOAD), .SWEEP_STEP4(SWEEP_STEP4), .ACCEPT(ACCEPT),
    .ERR_IN(ERR_IN), .ERA_CLR(ERA_CLR), .PA(PA), .PA_PAR(PA_PAR),
    .PA_VALID(PA_VALID), .GRANT(GRANT), .ERA(ERA), .ERA_FROZEN(ERA_FROZEN),
    .ERR_OVF(ERR_OVF), .SWEEP_ACTIVE(SWEEP_ACTIVE), .SWEEP_DONE(SWEEP_DONE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    RESET_N = 1'b1; VA = '0; BASE_LOAD = 1'b0; BASE_IDX = '0; BASE_SEL = '0;
    EBOX_REQ = 1'b0; PT_REQ = 1'b0; CHAN_REQ = '0; CHA_ADDR = '0; ERA_REQ = 1'b0;
    SWEEP_LOAD = 1'b0; SWEEP_STEP4 = 1'b0; ACCEPT = 1'b0; ERR_IN = 1'b0; ERA_CLR = 1'b0;
  endtask

  function automatic exp_t mk(input logic [PA_W-1:0] pa, input logic [NG-1:0] g);
    exp_t e;
    e.pa = pa;
    e.grant = g;
    return e;
  endfunction

  // Wait (bounded) for a presented cycle, drop the granted request, accept it
  task automatic serve(input logic err, output logic [PA_W-1:0] pa,
                       output logic [NG-1:0] g, output logic par, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (PA_VALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    pa = PA; g = GRANT; par = PA_PAR;
    if (g[0]) ERA_REQ = 1'b0;
    for (int i = 0; i < int'(NCHAN); i++) if (g[2+i]) CHAN_REQ[i] = 1'b0;
    if (g[NCHAN+2]) PT_REQ = 1'b0;
    if (g[NCHAN+3]) EBOX_REQ = 1'b0;
    ACCEPT = 1'b1; ERR_IN = err;
    tick();
    ACCEPT = 1'b0; ERR_IN = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; VA = '1; BASE_LOAD = 1'b1; BASE_IDX = 1'b1; BASE_SEL = 1'b1;
    EBOX_REQ = 1'b1; PT_REQ = 1'b1; CHAN_REQ = '1; CHA_ADDR = '1; ERA_REQ = 1'b1;
    SWEEP_LOAD = 1'b1; SWEEP_STEP4 = 1'b1; ACCEPT = 1'b1; ERR_IN = 1'b1; ERA_CLR = 1'b1;
    tick();
    n_tests++;
    if ({PA, PA_VALID, GRANT} !== '0) begin
      n_fail++; $display("FAIL reset_pa: pa=%h valid=%b grant=%h, want all 0", PA, PA_VALID, GRANT);
    end
    n_tests++;
    if (PA_PAR !== 1'b1) begin
      n_fail++; $display("FAIL reset_par: got %b want 1", PA_PAR);
    end
    n_tests++;
    if ({ERA, ERA_FROZEN, ERR_OVF} !== '0) begin
      n_fail++; $display("FAIL reset_era: era=%h frz=%b ovf=%b, want 0", ERA, ERA_FROZEN, ERR_OVF);
    end
    n_tests++;
    if ({SWEEP_ACTIVE, SWEEP_DONE} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sweep: act=%b done=%b, want 0 0", SWEEP_ACTIVE, SWEEP_DONE);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_priority();
    exp_t e; logic [PA_W-1:0] pa; logic [NG-1:0] g; logic par; bit ok;
    CHA_ADDR[PA_W +: PA_W] = 22'h02ABCD;
    CHA_ADDR[0 +: PA_W]    = 22'h000AAA;
    VA = 22'h3C1A5; BASE_SEL = 1'b0;
    EBOX_REQ = 1'b1; PT_REQ = 1'b1; CHAN_REQ = 2'b10;
    sb.push_back(mk(22'h02ABCD, G_CH1));
    sb.push_back(mk(22'h0001A5, G_PT));
    sb.push_back(mk(22'h3C1A5, G_EBOX));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      serve(1'b0, pa, g, par, ok);
      n_tests++;
      if (!ok || pa !== e.pa || g !== e.grant || par !== ~^e.pa) begin
        n_fail++;
        $display("FAIL prio: ok=%0d pa=%h grant=%h par=%b, want pa=%h grant=%h", ok, pa, g, par, e.pa, e.grant);
      end
    end
    CHAN_REQ = 2'b11; EBOX_REQ = 1'b1;
    sb.push_back(mk(22'h000AAA, G_CH0));
    sb.push_back(mk(22'h02ABCD, G_CH1));
    sb.push_back(mk(22'h3C1A5, G_EBOX));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      serve(1'b0, pa, g, par, ok);
      n_tests++;
      if (!ok || pa !== e.pa || g !== e.grant || par !== ~^e.pa) begin
        n_fail++;
        $display("FAIL prio_chan: ok=%0d pa=%h grant=%h par=%b, want pa=%h grant=%h", ok, pa, g, par, e.pa, e.grant);
      end
    end
  endtask

  task automatic test_base();
    exp_t e; logic [PA_W-1:0] pa; logic [NG-1:0] g; logic par; bit ok;
    // base 1 was held under load during reset and must still read zero
    BASE_SEL = 1'b1; VA = 22'h3FFE55; PT_REQ = 1'b1;
    sb.push_back(mk(22'h000055, G_PT));
    e = sb.pop_front();
    serve(1'b0, pa, g, par, ok);
    n_tests++;
    if (!ok || pa !== e.pa || g !== e.grant) begin
      n_fail++; $display("FAIL base_reset: pa=%h grant=%h, want pa=%h grant=%h", pa, g, e.pa, e.grant);
    end
    BASE_LOAD = 1'b1; BASE_IDX = 1'b1; VA = 22'h3FFE00;
    tick();
    BASE_LOAD = 1'b0;
    for (int k = 0; k < 2; k++) begin
      BASE_SEL = 1'(1 - k); VA = 22'h000123; PT_REQ = 1'b1;
      sb.push_back(mk(k == 0 ? 22'h3FFF23 : 22'h000123, G_PT));
      e = sb.pop_front();
      serve(1'b0, pa, g, par, ok);
      n_tests++;
      if (!ok || pa !== e.pa || g !== e.grant || par !== ~^e.pa) begin
        n_fail++; $display("FAIL base_pt%0d: pa=%h grant=%h, want pa=%h grant=%h", k, pa, g, e.pa, e.grant);
      end
    end
  endtask

  task automatic test_era();
    exp_t e; logic [PA_W-1:0] pa; logic [NG-1:0] g; logic par; bit ok;
    logic [PA_W-1:0] vas [3];
    logic [PA_W-1:0] want_era [3];
    vas[0] = 22'h000111; vas[1] = 22'h000222; vas[2] = 22'h000333;
    want_era[0] = 22'h000111; want_era[1] = 22'h000222; want_era[2] = 22'h000222;
    for (int k = 0; k < 3; k++) begin
      VA = vas[k]; EBOX_REQ = 1'b1;
      sb.push_back(mk(vas[k], G_EBOX));
      e = sb.pop_front();
      serve(k == 1, pa, g, par, ok);
      n_tests++;
      if (!ok || pa !== e.pa || g !== e.grant) begin
        n_fail++; $display("FAIL era_cycle%0d: pa=%h grant=%h, want pa=%h grant=%h", k, pa, g, e.pa, e.grant);
      end
      n_tests++;
      if (ERA !== want_era[k] || ERA_FROZEN !== (k != 0) || ERR_OVF !== 1'b0) begin
        n_fail++; $display("FAIL era_capture%0d: era=%h frz=%b ovf=%b, want era=%h frz=%b ovf=0",
                           k, ERA, ERA_FROZEN, ERR_OVF, want_era[k], k != 0);
      end
    end
    ERR_IN = 1'b1; tick(); ERR_IN = 1'b0;
    n_tests++;
    if (ERR_OVF !== 1'b1 || ERA_FROZEN !== 1'b1) begin
      n_fail++; $display("FAIL era_ovf: frz=%b ovf=%b, want 1 1", ERA_FROZEN, ERR_OVF);
    end
    ERA_REQ = 1'b1; EBOX_REQ = 1'b1; VA = 22'h000444;
    sb.push_back(mk(22'h000222, G_ERA));
    sb.push_back(mk(22'h000444, G_EBOX));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      serve(1'b0, pa, g, par, ok);
      n_tests++;
      if (!ok || pa !== e.pa || g !== e.grant || par !== ~^e.pa) begin
        n_fail++; $display("FAIL era_replay: pa=%h grant=%h, want pa=%h grant=%h", pa, g, e.pa, e.grant);
      end
    end
    ERA_CLR = 1'b1; tick(); ERA_CLR = 1'b0;
    n_tests++;
    if (ERA_FROZEN !== 1'b0 || ERR_OVF !== 1'b0 || ERA !== 22'h000222) begin
      n_fail++; $display("FAIL era_clr: era=%h frz=%b ovf=%b, want era=000222 0 0", ERA, ERA_FROZEN, ERR_OVF);
    end
    ERA_CLR = 1'b1; ERR_IN = 1'b1; tick(); ERA_CLR = 1'b0; ERR_IN = 1'b0;
    n_tests++;
    if (ERA_FROZEN !== 1'b1 || ERR_OVF !== 1'b0) begin
      n_fail++; $display("FAIL era_clr_err: frz=%b ovf=%b, want 1 0", ERA_FROZEN, ERR_OVF);
    end
    ERA_CLR = 1'b1; tick(); ERA_CLR = 1'b0;
  endtask

  task automatic test_sweep(input logic step4);
    exp_t e;
    int step = step4 ? 4 : 1;
    int n    = step4 ? 128 : 512;
    int dones = 0;
    logic [PA_W-1:0] last_pa = 22'h0005FF - PA_W'((n - 1) * step);
    for (int k = 0; k < n; k++) sb.push_back(mk(22'h0005FF - PA_W'(k * step), G_SWP));
    VA = 22'h000400; SWEEP_LOAD = 1'b1; SWEEP_STEP4 = step4;
    tick();
    SWEEP_LOAD = 1'b0; SWEEP_STEP4 = 1'b0; ACCEPT = 1'b1;
    for (int c = 0; c < 2 * n + 8; c++) begin
      tick();
      if (SWEEP_DONE === 1'b1) dones++;
      if (PA_VALID === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL sweep%0d_extra: unexpected pa=%h grant=%h", step, PA, GRANT);
        end else begin
          e = sb.pop_front();
          if (PA !== e.pa || GRANT !== e.grant || PA_PAR !== ~^e.pa) begin
            n_fail++; $display("FAIL sweep%0d_pa: pa=%h grant=%h par=%b, want pa=%h grant=%h",
                               step, PA, GRANT, PA_PAR, e.pa, e.grant);
          end
        end
      end
    end
    ACCEPT = 1'b0;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sweep%0d_timeout: %0d cycles missing, want 0", step, sb.size());
      sb.delete();
    end
    n_tests++;
    if (dones != 1 || SWEEP_ACTIVE !== 1'b0 || ERA !== last_pa) begin
      n_fail++; $display("FAIL sweep%0d_end: dones=%0d act=%b era=%h, want 1 0 %h",
                         step, dones, SWEEP_ACTIVE, ERA, last_pa);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    int dones = 0;
    for (int k = 0; k < 128; k++) sb.push_back(mk(22'h0005FF - PA_W'(k * 4), G_SWP));
    VA = 22'h000400; SWEEP_LOAD = 1'b1; SWEEP_STEP4 = 1'b1;
    tick();
    SWEEP_LOAD = 1'b0; SWEEP_STEP4 = 1'b0; ACCEPT = 1'b1;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      tick();
      if (SWEEP_DONE === 1'b1) dones++;
      if (PA_VALID === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (PA !== e.pa || GRANT !== e.grant) begin
          n_fail++; $display("FAIL coll_pa: pa=%h grant=%h, want pa=%h grant=%h", PA, GRANT, e.pa, e.grant);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL coll_timeout: %0d cycles missing, want 0", sb.size());
      sb.delete();
    end
    // reload lands on the edge that accepts the final stride-4 cycle
    SWEEP_LOAD = 1'b1; VA = 22'h000A00;
    tick();
    SWEEP_LOAD = 1'b0; ACCEPT = 1'b0;
    n_tests++;
    if (SWEEP_DONE !== 1'b0 || dones != 0 || SWEEP_ACTIVE !== 1'b1 || ERA !== 22'h000403) begin
      n_fail++; $display("FAIL coll_nodone: done=%b dones=%0d act=%b era=%h, want 0 0 1 000403",
                         SWEEP_DONE, dones, SWEEP_ACTIVE, ERA);
    end
    sb.push_back(mk(22'h000BFF, G_SWP));
    tick();
    e = sb.pop_front();
    n_tests++;
    if (PA_VALID !== 1'b1 || PA !== e.pa || GRANT !== e.grant) begin
      n_fail++; $display("FAIL coll_reload: valid=%b pa=%h grant=%h, want 1 %h %h", PA_VALID, PA, GRANT, e.pa, e.grant);
    end
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    n_tests++;
    if (PA_VALID !== 1'b0 || GRANT !== '0 || PA !== '0 || SWEEP_ACTIVE !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: valid=%b grant=%h pa=%h act=%b, want 0 0 0 0", PA_VALID, GRANT, PA, SWEEP_ACTIVE);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_priority();
    test_base();
    test_era();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
